// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the HI/LO multiply/divide controller:
//   - OP_* encodings carried on the controller's 2-bit op port
//   - ALUOp (MIPS funct) values that select each mul/div operation
//   - state encoding of the controller FSM
//   - small decode helpers used by the decoder and the datapath
package mips_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // The decoder forwards the R-type funct field as ALUOp; the four mul/div
  // functs share their upper bits, so the low two bits are the op code.
  localparam logic [5:0] ALUOP_MULT  = 6'h18;
  localparam logic [5:0] ALUOP_MULTU = 6'h19;
  localparam logic [5:0] ALUOP_DIV   = 6'h1A;
  localparam logic [5:0] ALUOP_DIVU  = 6'h1B;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_FIXUP = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    CALC  = ST_CALC,
    FIXUP = ST_FIXUP,
    DONE  = ST_DONE
  } md_state_t;

  function automatic logic is_muldiv_aluop(input logic [5:0] aluop);
    return aluop[5:2] == ALUOP_MULT[5:2];
  endfunction

  function automatic logic [1:0] aluop_to_md_op(input logic [5:0] aluop);
    return aluop[1:0];
  endfunction

  function automatic logic is_div_op(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_engine.sv
// muldiv_engine
// Datapath of the HI/LO unit: operand/accumulator registers, one iteration
// of shift-add multiply or restoring divide per step, and the final sign fix.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   load              capture operands (magnitudes for signed ops)
//   step              run one engine iteration
//   fix               apply sign/div-by-zero fixup and load hilo_wdata
//   op                operation code (OP_*), sampled with load
//   src_a, src_b      raw operands
//   hilo_wdata        registered {HI,LO} result, held between operations
module muldiv_engine
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic                  fix,
  input  logic [1:0]            op,
  input  logic [DATA_W-1:0]     src_a,
  input  logic [DATA_W-1:0]     src_b,
  output logic [2*DATA_W-1:0]   hilo_wdata
);

  // acc holds {HI,LO} of the product while multiplying and {rem,quot}
  // while dividing; opnd is the multiplicand or the divisor.
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   opnd;
  logic [DATA_W-1:0]   orig_a;
  logic                is_div_q;
  logic                neg_q;
  logic                neg_r;

  logic                signed_in;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [DATA_W-1:0]   acc_hi;
  logic [DATA_W-1:0]   acc_lo;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     rem_sh;
  logic                rem_ge;
  logic [DATA_W-1:0]   rem_new;
  logic [2*DATA_W-1:0] step_val;
  logic [2*DATA_W-1:0] fix_val;

  assign acc_hi = acc[2*DATA_W-1:DATA_W];
  assign acc_lo = acc[DATA_W-1:0];

  // Operand magnitudes; signed ops run the unsigned engine on |a|, |b|.
  always_comb begin
    signed_in = is_signed_op(op);
    mag_a     = (signed_in && src_a[DATA_W-1]) ? -src_a : src_a;
    mag_b     = (signed_in && src_b[DATA_W-1]) ? -src_b : src_b;
  end

  // One iteration. Multiply adds the multiplicand into HI when the current
  // multiplier LSB is set, then shifts {carry,HI,LO} right. Divide shifts
  // {rem,quot} left and keeps the trial difference when it does not borrow.
  always_comb begin
    mul_sum  = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opnd}) : {1'b0, acc_hi};
    rem_sh   = {acc_hi, acc_lo[DATA_W-1]};
    rem_ge   = rem_sh >= {1'b0, opnd};
    rem_new  = rem_ge ? DATA_W'(rem_sh - {1'b0, opnd}) : rem_sh[DATA_W-1:0];
    step_val = is_div_q ? {rem_new, acc_lo[DATA_W-2:0], rem_ge}
                        : {mul_sum, acc_lo[DATA_W-1:1]};
  end

  // Sign restoration. A zero divisor bypasses the engine result entirely
  // and reports all-ones quotient with the untouched dividend as remainder.
  always_comb begin
    fix_val = acc;
    if (!is_div_q) begin
      fix_val = neg_q ? -acc : acc;
    end else if (opnd == '0) begin
      fix_val = {orig_a, {DATA_W{1'b1}}};
    end else begin
      fix_val = {(neg_r ? -acc_hi : acc_hi), (neg_q ? -acc_lo : acc_lo)};
    end
  end

  // Datapath registers; hilo_wdata changes only on a completed fixup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      opnd       <= '0;
      orig_a     <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      hilo_wdata <= '0;
    end else begin
      if (load) begin
        is_div_q <= is_div_op(op);
        neg_q    <= signed_in & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
        neg_r    <= signed_in & src_a[DATA_W-1];
        orig_a   <= src_a;
        opnd     <= is_div_op(op) ? mag_b : mag_a;
        acc      <= {{DATA_W{1'b0}}, (is_div_op(op) ? mag_a : mag_b)};
      end else if (step) begin
        acc <= step_val;
      end
      if (fix) begin
        hilo_wdata <= fix_val;
      end
    end
  end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl
// Multi-cycle MULT/MULTU/DIV/DIVU controller beside the EX-stage ALU.
// Stalls IF/ID/EX while busy and emits a one-cycle HI/LO write strobe.
// ITER must equal DATA_W (one engine iteration per operand bit).
// Ports:
//   clk, rst          pipeline clock, asynchronous active-low reset
//   start             EX holds a mul/div (sampled only in IDLE)
//   op                OP_MULT / OP_MULTU / OP_DIV / OP_DIVU
//   src_a, src_b      forwarded Rs / Rt values
//   flush             exception flush; aborts any operation
//   stall             hold IF/ID/EX
//   busy              state != IDLE
//   hilo_we           one-cycle HI/LO write strobe
//   hilo_wdata        {HI,LO} write data
module muldiv_hilo_ctrl
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ITER   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_W-1:0]     src_a,
  input  logic [DATA_W-1:0]     src_b,
  input  logic                  flush,
  output logic                  stall,
  output logic                  busy,
  output logic                  hilo_we,
  output logic [2*DATA_W-1:0]   hilo_wdata
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  md_state_t        state;
  md_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             step;
  logic             fix;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Iteration counter, restarted whenever operands are captured
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Next state; flush overrides every state so an exception always wins
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = CALC;
        CALC:    if (cnt == LAST_CNT) state_nxt = FIXUP;
        FIXUP:   state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs and datapath strobes. stall covers the start cycle too, and
  // drops in DONE so the instruction leaves EX on the HI/LO write edge.
  always_comb begin
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    hilo_we = 1'b0;
    stall   = 1'b0;
    busy    = (state != IDLE);
    if (!flush) begin
      case (state)
        IDLE: begin
          load  = start;
          stall = start;
        end
        CALC: begin
          step  = 1'b1;
          stall = 1'b1;
        end
        FIXUP: begin
          fix   = 1'b1;
          stall = 1'b1;
        end
        DONE:    hilo_we = 1'b1;
        default: ;
      endcase
    end
  end

  muldiv_engine #(
    .DATA_W (DATA_W)
  ) u_engine (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .fix        (fix),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .hilo_wdata (hilo_wdata)
  );

endmodule
